// File: rtl/risci_pkg.sv
// rtl/risci_pkg.sv - shared widths, access-size encodings and arbiter enums for the risci memory arbiter
package risci_pkg;

    localparam int VLEN = 64;
    localparam int DLEN = 64;
    localparam int ILEN = 32;

    localparam logic [1:0] LEN_8  = 2'b00;
    localparam logic [1:0] LEN_16 = 2'b01;
    localparam logic [1:0] LEN_32 = 2'b10;
    localparam logic [1:0] LEN_64 = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/risci_starve_ctr.sv
// rtl/risci_starve_ctr.sv - counts back-to-back data grants while a fetch waits; flags when fetch must win
module risci_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic grant_i,
    input  logic grant_d,
    output logic starve
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // saturates at LIMIT so the flag stays up until the fetch is actually granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!i_req || grant_i) begin
            cnt <= '0;
        end else if (grant_d && (cnt < CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starve = (cnt >= CW'(LIMIT));

endmodule

// File: rtl/risci_mem_arbiter.sv
// rtl/risci_mem_arbiter.sv - two-port (fetch/data) to one-port memory arbiter; optional RISCI_ARB_STARVE_GUARD_EN
module risci_mem_arbiter
    import risci_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hlt,
    input  logic            i_req,
    input  logic [VLEN-1:0] i_addr,
    output logic [ILEN-1:0] i_rdata,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [VLEN-1:0] d_addr,
    input  logic [DLEN-1:0] d_wdata,
    input  logic [1:0]      d_len,
    output logic [DLEN-1:0] d_rdata,
    output logic            d_ack,
    output logic            m_req,
    output logic            m_we,
    output logic [VLEN-1:0] m_addr,
    output logic [DLEN-1:0] m_wdata,
    output logic [1:0]      m_len,
    input  logic [DLEN-1:0] m_rdata,
    input  logic            m_ack
);

    localparam logic [1:0] S_IDLE = ARB_IDLE;
    localparam logic [1:0] S_BUSY = ARB_BUSY;
    localparam logic [1:0] S_RESP = ARB_RESP;

    logic [1:0] state;
    owner_e     owner;
    logic       grant;
    logic       pick_i;
    logic       grant_i;
    logic       grant_d;
    logic       starve;

`ifdef RISCI_ARB_STARVE_GUARD_EN
    risci_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_req),
        .grant_i(grant_i),
        .grant_d(grant_d),
        .starve (starve)
    );
`else
    // strict data priority: the limit has no effect in this build
    assign starve = (STARVE_LIMIT < 0);
`endif

    assign grant   = (state == S_IDLE) && !hlt && (i_req || d_req);
    assign pick_i  = i_req && (!d_req || starve);
    assign grant_i = grant && pick_i;
    assign grant_d = grant && !pick_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            owner   <= OWN_INSTR;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_len   <= 2'b00;
            i_rdata <= '0;
            i_ack   <= 1'b0;
            d_rdata <= '0;
            d_ack   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state <= S_BUSY;
                        m_req <= 1'b1;
                        if (pick_i) begin
                            owner   <= OWN_INSTR;
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_len   <= LEN_32;
                        end else begin
                            owner   <= OWN_DATA;
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_len   <= d_len;
                        end
                    end
                end
                S_BUSY: begin
                    if (m_ack) begin
                        state <= S_RESP;
                        m_req <= 1'b0;
                        if (owner == OWN_INSTR) begin
                            i_rdata <= m_rdata[ILEN-1:0];
                            i_ack   <= 1'b1;
                        end else begin
                            d_rdata <= m_rdata;
                            d_ack   <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risci_mem_arbiter.sv
// tb/tb_risci_mem_arbiter.sv - self-checking bench for risci_mem_arbiter with a transaction-level reference model
module tb_risci_mem_arbiter;
    import risci_pkg::*;

    localparam int LIMIT = 4;
`ifdef RISCI_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            hlt;
    logic            i_req;
    logic [VLEN-1:0] i_addr;
    logic [ILEN-1:0] i_rdata;
    logic            i_ack;
    logic            d_req;
    logic            d_we;
    logic [VLEN-1:0] d_addr;
    logic [DLEN-1:0] d_wdata;
    logic [1:0]      d_len;
    logic [DLEN-1:0] d_rdata;
    logic            d_ack;
    logic            m_req;
    logic            m_we;
    logic [VLEN-1:0] m_addr;
    logic [DLEN-1:0] m_wdata;
    logic [1:0]      m_len;
    logic [DLEN-1:0] m_rdata;
    logic            m_ack;

    int          checks = 0;
    int          errors = 0;
    int          starve_cnt = 0;
    logic [31:0] exp_ir = '0;
    logic [63:0] exp_dr = '0;

    risci_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .hlt    (hlt),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_rdata(i_rdata),
        .i_ack  (i_ack),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_len  (d_len),
        .d_rdata(d_rdata),
        .d_ack  (d_ack),
        .m_req  (m_req),
        .m_we   (m_we),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_len  (m_len),
        .m_rdata(m_rdata),
        .m_ack  (m_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: data wins unless a fetch has waited through LIMIT data grants
    task automatic model_grant(input logic ir, input logic dr, output logic is_i);
        if (!ir) starve_cnt = 0;
        is_i = ir && (!dr || (GUARD && starve_cnt >= LIMIT));
        if (is_i) starve_cnt = 0;
        else if (ir) starve_cnt++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_i_rdata"}, 64'(i_rdata), 64'd0);
        chk({tag, "_i_ack"},   64'(i_ack),   64'd0);
        chk({tag, "_d_rdata"}, d_rdata,      64'd0);
        chk({tag, "_d_ack"},   64'(d_ack),   64'd0);
        chk({tag, "_m_req"},   64'(m_req),   64'd0);
        chk({tag, "_m_we"},    64'(m_we),    64'd0);
        chk({tag, "_m_addr"},  m_addr,       64'd0);
        chk({tag, "_m_wdata"}, m_wdata,      64'd0);
        chk({tag, "_m_len"},   64'(m_len),   64'd0);
    endtask

    // Requests already driven; waits for grant, checks the bus, acks after wt cycles, checks response.
    task automatic run_txn(input logic is_i, input logic [63:0] a, input logic we,
                           input logic [1:0] len, input logic [63:0] wd, input int wt,
                           input logic [63:0] rd, output int gl);
        gl = 0;
        for (int k = 0; k < 8 && m_req !== 1'b1; k++) begin
            step();
            gl++;
        end
        chk("grant",   64'(m_req), 64'd1);
        chk("m_addr",  m_addr, a);
        chk("m_we",    64'(m_we), 64'(we));
        chk("m_len",   64'(m_len), 64'(len));
        chk("m_wdata", m_wdata, wd);
        for (int k = 0; k < wt; k++) begin
            step();
            chk("hold_req", 64'(m_req), 64'd1);
        end
        chk("hold_addr",  m_addr, a);
        chk("hold_wdata", m_wdata, wd);
        m_ack   = 1'b1;
        m_rdata = rd;
        step();
        m_ack   = 1'b0;
        m_rdata = {$urandom, $urandom};
        if (is_i) exp_ir = rd[31:0];
        else      exp_dr = rd;
        chk("i_ack",     64'(i_ack), 64'(is_i));
        chk("d_ack",     64'(d_ack), 64'(!is_i));
        chk("m_req_off", 64'(m_req), 64'd0);
        chk("i_rdata",   64'(i_rdata), 64'(exp_ir));
        chk("d_rdata",   d_rdata, exp_dr);
        step();
        chk("ack_pulse",     64'({i_ack, d_ack}), 64'd0);
        chk("no_grant_resp", 64'(m_req), 64'd0);
    endtask

    initial begin
        logic        is_i;
        int          gl;
        int          n_i;
        int          r;
        logic [63:0] rd;

        rst = 1'b0; hlt = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_len = 2'b00;
        m_rdata = '0; m_ack = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b1;
        step();
        chk("idle_no_req", 64'(m_req), 64'd0);

        // single fetch, memory acks one cycle after m_req
        i_req = 1'b1; i_addr = 64'h100;
        model_grant(i_req, d_req, is_i);
        run_txn(1'b1, 64'h100, 1'b0, LEN_32, 64'd0, 1, 64'hDEAD_BEEF_1234_5678, gl);
        chk("fetch_grant_lat", 64'(gl), 64'd1);
        chk("fetch_rdata", 64'(i_rdata), 64'h1234_5678);
        i_req = 1'b0;
        step();

        // simultaneous requests: data first, fetch after RESP
        i_req = 1'b1; i_addr = 64'h100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2000; d_wdata = 64'hAA; d_len = LEN_8;
        model_grant(i_req, d_req, is_i);
        chk("both_model_d", 64'(is_i), 64'd0);
        run_txn(1'b0, 64'h2000, 1'b1, LEN_8, 64'hAA, 0, 64'h0, gl);
        d_req = 1'b0;
        model_grant(i_req, d_req, is_i);
        run_txn(1'b1, 64'h100, 1'b0, LEN_32, 64'd0, 0, 64'h5555_6666_7777_8888, gl);
        chk("fetch_after_resp_lat", 64'(gl), 64'd1);
        i_req = 1'b0;
        step();

        // both held: starvation guard pattern
        i_req = 1'b1; i_addr = 64'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000; d_wdata = 64'h1; d_len = LEN_64;
        n_i = 0;
        for (int t = 0; t < 10; t++) begin
            model_grant(i_req, d_req, is_i);
            if (is_i) n_i++;
            rd = {$urandom, $urandom};
            if (is_i) run_txn(1'b1, 64'h400, 1'b0, LEN_32, 64'd0, 0, rd, gl);
            else      run_txn(1'b0, 64'h8000, 1'b0, LEN_64, 64'h1, 0, rd, gl);
        end
        chk("starve_fetch_count", 64'(n_i), GUARD ? 64'd2 : 64'd0);
        i_req = 1'b0; d_req = 1'b0;
        step();

        // hlt while BUSY: current transfer completes, nothing new until hlt drops
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h3000; d_wdata = 64'h0; d_len = LEN_64;
        model_grant(i_req, d_req, is_i);
        step();
        chk("hlt_busy_req", 64'(m_req), 64'd1);
        hlt = 1'b1; m_ack = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        m_ack = 1'b0;
        exp_dr = 64'h0123_4567_89AB_CDEF;
        chk("hlt_d_ack", 64'(d_ack), 64'd1);
        chk("hlt_d_rdata", d_rdata, exp_dr);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hlt_blocked", 64'(m_req), 64'd0);
        end
        hlt = 1'b0;
        model_grant(i_req, d_req, is_i);
        run_txn(1'b0, 64'h3000, 1'b0, LEN_64, 64'h0, 2, 64'hFEED_FACE_CAFE_F00D, gl);
        chk("hlt_release_lat", 64'(gl), 64'd1);
        d_req = 1'b0;
        step();

        // reset while BUSY, then a late m_ack
        d_req = 1'b1; d_addr = 64'h3300; d_we = 1'b1; d_wdata = 64'h77;
        step();
        chk("rst_busy_req", 64'(m_req), 64'd1);
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        d_req = 1'b0;
        exp_ir = '0; exp_dr = '0; starve_cnt = 0;
        step();
        rst = 1'b1; m_ack = 1'b1; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        chk("late_ack_i", 64'(i_ack), 64'd0);
        chk("late_ack_d", 64'(d_ack), 64'd0);
        step();
        m_ack = 1'b0;
        chk_all_zero("after_late_ack");
        i_req = 1'b1; i_addr = 64'h40;
        model_grant(i_req, d_req, is_i);
        run_txn(1'b1, 64'h40, 1'b0, LEN_32, 64'd0, 0, 64'h1111_2222_3333_4444, gl);
        chk("post_rst_idle_lat", 64'(gl), 64'd1);
        i_req = 1'b0;
        step();

        // randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 3);
            i_req   = (r != 1);
            d_req   = (r != 0);
            i_addr  = {$urandom, $urandom};
            d_addr  = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
            d_we    = 1'($urandom_range(0, 1));
            d_len   = 2'($urandom_range(0, 3));
            rd      = {$urandom, $urandom};
            model_grant(i_req, d_req, is_i);
            if (is_i) run_txn(1'b1, i_addr, 1'b0, LEN_32, 64'd0, $urandom_range(0, 3), rd, gl);
            else      run_txn(1'b0, d_addr, d_we, d_len, d_wdata, $urandom_range(0, 3), rd, gl);
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        chk("final_idle", 64'(m_req), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
